rx: RTL and testbench

UART receiver that consumes the serial stream produced by `tx_top` (the `UART_RXD_OUT` line) and recovers each byte. It is the synthesizable receive stage that replaces the behavioural receive model on the far end of the TX path. It also serves as the receive half of the upcoming loopback top level. Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).

---
 rtl/uart_pkg.sv | 18 +
 rtl/rx_sync.sv | 24 ++
 rtl/rx.sv | 144 ++++++++++++++
 tb/tb_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state type.
// Used by rx, rx_sync and the tx path.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer with a parameterized reset value.
// Ports: clk, rst (sync, active high), d (async in), q (synced out).
module rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx.sv
// UART receiver: 1 start, 8 data LSB first, 1 parity, 1 stop.
// Ports: clk, rst (sync, active high), din (async serial, idles high),
//        dout (last byte), busy, data_strobe (1-cycle), rx_error.
// Option: RX_MAJORITY_VOTE_EN = 3-sample majority vote per bit.
module rx
    import uart_pkg::*;
#(
    parameter int   CLK_FREQUENCY = 100_000_000,
    parameter int   BAUD_RATE     = 19_200,
    parameter logic PARITY        = PARITY_ODD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 busy,
    output logic                 data_strobe,
    output logic                 rx_error
);

    localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF        = BAUD_CLOCKS / 2;

`ifdef RX_MAJORITY_VOTE_EN
    // Decision lands one count late; reloading with 1 keeps the
    // bit period at BAUD_CLOCKS so sample points do not drift.
    localparam int CW       = $clog2(BAUD_CLOCKS + 1);
    localparam int START_AT = HALF;
    localparam int BIT_AT   = BAUD_CLOCKS;
    localparam int RELOAD   = 1;
`else
    localparam int CW       = $clog2(BAUD_CLOCKS);
    localparam int START_AT = HALF - 1;
    localparam int BIT_AT   = BAUD_CLOCKS - 1;
    localparam int RELOAD   = 0;
`endif

    rx_state_t              state;
    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   parbit;
    logic                   s;
    logic                   s_prev;
    logic                   fall;
    logic                   tick;
    logic                   bitval;

    rx_sync #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (s)
    );

    assign fall = s_prev & ~s;

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], s};
    end

    assign bitval = (hist[1] & hist[0]) | (hist[1] & s) | (hist[0] & s);
`else
    assign bitval = s;
`endif

    always_comb begin
        tick = 1'b0;
        if (state == RX_START) tick = (cnt == CW'(START_AT));
        else                   tick = (cnt == CW'(BIT_AT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            parbit      <= 1'b0;
            s_prev      <= 1'b1;
            dout        <= '0;
            busy        <= 1'b0;
            data_strobe <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            s_prev      <= s;
            data_strobe <= 1'b0;
            cnt         <= cnt + CW'(1);
            unique case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state <= RX_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (bitval) begin
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RX_DATA;
                            cnt   <= CW'(RELOAD);
                            idx   <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        shreg[idx] <= bitval;
                        idx        <= idx + 3'd1;
                        cnt        <= CW'(RELOAD);
                        if (idx == 3'd7) state <= RX_PAR;
                    end
                end
                RX_PAR: begin
                    if (tick) begin
                        parbit <= bitval;
                        cnt    <= CW'(RELOAD);
                        state  <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        dout        <= shreg;
                        rx_error    <= ((^shreg ^ parbit) != PARITY) | ~bitval;
                        data_strobe <= 1'b1;
                        busy        <= 1'b0;
                        state       <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: fast-baud instance with a frame model,
// plus one full-rate 100 MHz / 19200 frame for absolute latency.
module tb_rx;

    localparam int CF = 1_250_000;
    localparam int BR = 100_000;
    localparam int B  = CF / BR;
    localparam int H  = B / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int SOFF = 3 + H + 10 * B + LAT;
    localparam int BF   = 100_000_000 / 19_200;

    logic       clk = 1'b0;
    logic       rst, din;
    logic [7:0] dout;
    logic       busy, data_strobe, rx_error;

    logic       rst_f, din_f;
    logic [7:0] dout_f;
    logic       busy_f, stb_f, err_f;

    always #5 clk = ~clk;

    rx #(
        .CLK_FREQUENCY(CF),
        .BAUD_RATE    (BR),
        .PARITY       (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dout       (dout),
        .busy       (busy),
        .data_strobe(data_strobe),
        .rx_error   (rx_error)
    );

    rx u_full (
        .clk        (clk),
        .rst        (rst_f),
        .din        (din_f),
        .dout       (dout_f),
        .busy       (busy_f),
        .data_strobe(stb_f),
        .rx_error   (err_f)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         busy_from = 0;
    int         busy_to = 0;
    int         last_stb = -1;
    logic       in_rst = 1'b1;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_err = 1'b0;
    logic       es;
    logic       full_done = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     n, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the frame model.
    always @(negedge clk) begin
        if (!in_rst) begin
            es = (q.size() > 0) && (q[0].cyc == cyc);
            if (es) begin
                exp_dout = q[0].d;
                exp_err  = q[0].e;
                void'(q.pop_front());
            end
            chk("strobe", 32'(data_strobe), 32'(es));
            chk("dout", 32'(dout), 32'(exp_dout));
            chk("rx_error", 32'(rx_error), 32'(exp_err));
            chk("busy", 32'(busy),
                32'(cyc >= busy_from && cyc < busy_to));
        end
        if (data_strobe) last_stb = cyc;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        in_rst = 1'b1;
        q.delete();
        busy_from = 0;
        busy_to   = 0;
        step(5);
        rst      = 1'b0;
        exp_dout = 8'h00;
        exp_err  = 1'b0;
        in_rst   = 1'b0;
    endtask

    // Called just after a clock edge. abort_bit >= 0 cuts the frame at
    // that bit and resets; glitch_c flips din for one cycle at offset c.
    task automatic send(input logic [7:0] d, input logic par,
                        input logic stp, input int abort_bit,
                        input int glitch_c, output int t0);
        logic [10:0] f;
        f  = {stp, par, d, 1'b0};
        t0 = cyc;
        busy_from = t0 + 3;
        if (abort_bit < 0) begin
            busy_to = t0 + SOFF;
            q.push_back('{t0 + SOFF, d, ((^d ^ par) != 1'b1) || !stp});
        end else begin
            busy_to = 32'h7fff_ffff;
        end
        for (int c = 0; c < 11 * B; c++) begin
            if (abort_bit >= 0 && c == abort_bit * B) break;
            din = f[c / B] ^ (c == glitch_c);
            step(1);
        end
        if (abort_bit >= 0) begin
            din = 1'b1;
            do_reset();
        end
    endtask

    task automatic pulse(input int len);
        int t0;
        t0 = cyc;
        busy_from = t0 + 3;
        busy_to   = t0 + 3 + H + LAT;
        din = 1'b0;
        step(len);
        din = 1'b1;
    endtask

    initial begin
        int         t0;
        int         snap;
        logic [7:0] r;
        rst = 1'b1;
        din = 1'b1;
        step(5);
        rst    = 1'b0;
        in_rst = 1'b0;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobe", 32'(data_strobe), 32'h0);
        chk("rst_err", 32'(rx_error), 32'h0);
        step(300);
        chk("idle_nostb", last_stb, -1);

        // B=12, H=6: strobe 3+6+120 = 129 cycles after din falls.
        send(8'hA5, 1'b1, 1'b1, -1, -1, t0);
        chk("a5_lat", last_stb - t0, 129 + LAT);
        chk("a5_dout", 32'(dout), 32'hA5);
        chk("a5_err", 32'(rx_error), 32'h0);
        step(4);

        send(8'h3C, 1'b0, 1'b1, -1, -1, t0);
        chk("par_dout", 32'(dout), 32'h3C);
        chk("par_err", 32'(rx_error), 32'h1);
        step(4);

        send(8'h00, 1'b1, 1'b0, -1, -1, t0);
        chk("frm_err", 32'(rx_error), 32'h1);
        chk("frm_dout", 32'(dout), 32'h00);
        snap = last_stb;
        step(5 * B);
        chk("frm_low_nostb", last_stb, snap);
        din = 1'b1;
        step(2 * B);
        send(8'h55, 1'b1, 1'b1, -1, -1, t0);
        chk("frm_next_dout", 32'(dout), 32'h55);
        chk("frm_next_err", 32'(rx_error), 32'h0);
        step(4);

        snap = last_stb;
        pulse(3);
        step(3 * B);
        chk("fs_nostb", last_stb, snap);

        for (int i = 0; i < 5; i++) begin
            r = 8'($urandom);
            send(r, ~^r, 1'b1, -1, -1, t0);
        end
        chk("rnd_err", 32'(rx_error), 32'h0);
        step(4);

        snap = last_stb;
        send(8'hC3, 1'b1, 1'b1, 4, -1, t0);
        step(3 * B);
        chk("abort_nostb", last_stb, snap);
        chk("abort_dout", 32'(dout), 32'h00);
        send(8'h0F, 1'b1, 1'b1, -1, -1, t0);
        chk("recover_dout", 32'(dout), 32'h0F);
        step(4);

`ifdef RX_MAJORITY_VOTE_EN
        // Data bit 3 of 5A is 1; a lone low cycle at its centre is voted out.
        send(8'h5A, 1'b1, 1'b1, -1, H + 4 * B, t0);
        chk("glitch_dout", 32'(dout), 32'h5A);
        chk("glitch_err", 32'(rx_error), 32'h0);
        step(4);
`endif

        wait (full_done);
        step(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    // Full-rate frame: strobe 2+54685 = 54687 cycles after din falls.
    initial begin
        int          t0f;
        int          nstb;
        int          stb_at;
        logic        stb_busy;
        logic [10:0] f;
        rst_f = 1'b1;
        din_f = 1'b1;
        nstb  = 0;
        stb_at   = -1;
        stb_busy = 1'b1;
        step(5);
        rst_f = 1'b0;
        chk("full_rst_dout", 32'(dout_f), 32'h00);
        step(10);
        f   = {1'b1, 1'b1, 8'hA5, 1'b0};
        t0f = cyc;
        for (int c = 0; c < 11 * BF; c++) begin
            din_f = f[c / BF];
            step(1);
            if (cyc == t0f + 2) chk("full_busy_pre", 32'(busy_f), 32'h0);
            if (cyc == t0f + 3) chk("full_busy_on", 32'(busy_f), 32'h1);
            if (stb_f) begin
                nstb++;
                stb_at   = cyc;
                stb_busy = busy_f;
            end
        end
        chk("full_nstb", nstb, 1);
        chk("full_lat", stb_at - t0f, 54687 + LAT);
        chk("full_dout", 32'(dout_f), 32'hA5);
        chk("full_err", 32'(err_f), 32'h0);
        chk("full_busy_at_stb", 32'(stb_busy), 32'h0);
        full_done = 1'b1;
    end

endmodule
